// File: rtl/vmicro16_bram_dp_pkg.sv
// Shared memory definitions: read-during-write modes and clear-sequencer states.
package vmicro16_bram_dp_pkg;

    localparam int BRAM_WRITE_FIRST = 0;
    localparam int BRAM_READ_FIRST  = 1;
    localparam int BRAM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clr_state_t;

endpackage

// File: rtl/vmicro16_bram_clr_seq.sv
// Post-reset clear sequencer: writes one cell per clock from 0 to MEM_DEPTH-1, then idles.
// busy is registered and stays high in reset; no backpressure, it simply owns port A while clearing.
module vmicro16_bram_clr_seq
    import vmicro16_bram_dp_pkg::*;
#(
    parameter int                   MEM_WIDTH   = 16,
    parameter int                   MEM_DEPTH   = 256,
    parameter int                   ADDR_WIDTH  = 8,
    parameter logic [MEM_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter bit                   DO_CLEAR    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [MEM_WIDTH-1:0]  clr_dat,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MEM_DEPTH - 1);

    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            // Pointer parks on the last cell rather than wrapping back to 0.
            if (clr_ptr_q == LAST_PTR) begin
                state_d = ST_RUN;
            end else begin
                clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
            end
        end
        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DO_CLEAR ? ST_CLEAR : ST_RUN;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    assign clr_we   = (state_q == ST_CLEAR) && !reset;
    assign clr_addr = clr_ptr_q;
    assign clr_dat  = CLEAR_VALUE;
    assign busy     = busy_q;

endmodule

// File: rtl/vmicro16_bram_dp.sv
// True dual-port BRAM with per-port read-during-write mode and hardware clear after reset.
// 1-cycle read latency, back-to-back on both ports; requests dropped (no valid) while busy.
module vmicro16_bram_dp
    import vmicro16_bram_dp_pkg::*;
#(
    parameter int                   MEM_WIDTH   = 16,
    parameter int                   MEM_DEPTH   = 256,
    parameter int                   ADDR_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
    parameter int                   WRITE_MODE  = BRAM_WRITE_FIRST,
    parameter logic [MEM_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter bit                   DO_CLEAR    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [MEM_WIDTH-1:0]  a_din,
    output logic [MEM_WIDTH-1:0]  a_dout,
    output logic                  a_valid,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [MEM_WIDTH-1:0]  b_din,
    output logic [MEM_WIDTH-1:0]  b_dout,
    output logic                  b_valid,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [MEM_WIDTH-1:0]  clr_dat;

    logic                  a_acc, a_inr, b_acc, b_inr;
    logic [MEM_WIDTH-1:0]  a_rd, b_rd;
    logic                  a_wr, b_wr;
    logic [ADDR_WIDTH-1:0] a_waddr;
    logic [MEM_WIDTH-1:0]  a_wdat;
    logic [MEM_WIDTH-1:0]  a_dout_q, a_dout_d, b_dout_q, b_dout_d;
    logic                  a_valid_q, a_valid_d, b_valid_q, b_valid_d;

    vmicro16_bram_clr_seq #(
        .MEM_WIDTH  (MEM_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CLEAR_VALUE(CLEAR_VALUE),
        .DO_CLEAR   (DO_CLEAR)
    ) u_clr_seq (
        .clk     (clk),
        .reset   (reset),
        .clr_we  (clr_we),
        .clr_addr(clr_addr),
        .clr_dat (clr_dat),
        .busy    (busy)
    );

    always_comb begin
        a_acc = a_en && !busy && !reset;
        b_acc = b_en && !busy && !reset;
        a_inr = {1'b0, a_addr} < DEPTH_L;
        b_inr = {1'b0, b_addr} < DEPTH_L;
        a_rd  = a_inr ? mem[a_addr] : '0;
        b_rd  = b_inr ? mem[b_addr] : '0;

        // The clear sequencer borrows port A's write path.
        a_wr    = clr_we || (a_acc && a_we && a_inr);
        a_waddr = clr_we ? clr_addr : a_addr;
        a_wdat  = clr_we ? clr_dat  : a_din;
        b_wr    = b_acc && b_we && b_inr;

        a_dout_d  = a_dout_q;
        a_valid_d = a_acc;
        if (a_acc) begin
            if (!a_we) begin
                a_dout_d = a_rd;
            end else begin
                case (WRITE_MODE)
                    BRAM_WRITE_FIRST: a_dout_d = a_din;
                    BRAM_READ_FIRST:  a_dout_d = a_rd;
                    default:          a_dout_d = a_dout_q;
                endcase
            end
        end

        b_dout_d  = b_dout_q;
        b_valid_d = b_acc;
        if (b_acc) begin
            if (!b_we) begin
                b_dout_d = b_rd;
            end else begin
                case (WRITE_MODE)
                    BRAM_WRITE_FIRST: b_dout_d = b_din;
                    BRAM_READ_FIRST:  b_dout_d = b_rd;
                    default:          b_dout_d = b_dout_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout_q  <= '0;
            b_dout_q  <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            a_dout_q  <= a_dout_d;
            b_dout_q  <= b_dout_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    // Port A is applied last so it wins a same-address write collision.
    always_ff @(posedge clk) begin
        if (b_wr) mem[b_addr]  <= b_din;
        if (a_wr) mem[a_waddr] <= a_wdat;
    end

    assign a_dout  = a_dout_q;
    assign b_dout  = b_dout_q;
    assign a_valid = a_valid_q;
    assign b_valid = b_valid_q;

endmodule

// File: tb/tb_vmicro16_bram_dp.sv
// Directed bench: u0/u1/u2 are 16-deep in WRITE_FIRST/READ_FIRST/NO_CHANGE, u3 is 12-deep WRITE_FIRST.
module tb_vmicro16_bram_dp;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_en, a_we, b_en, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;
    logic [15:0] a_dout [4];
    logic [15:0] b_dout [4];
    logic        a_valid [4];
    logic        b_valid [4];
    logic        busy [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vmicro16_bram_dp #(.MEM_WIDTH(16), .MEM_DEPTH(16), .WRITE_MODE(0)) u0 (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[0]), .a_valid(a_valid[0]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout[0]), .b_valid(b_valid[0]),
        .busy(busy[0]));
    vmicro16_bram_dp #(.MEM_WIDTH(16), .MEM_DEPTH(16), .WRITE_MODE(1)) u1 (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[1]), .a_valid(a_valid[1]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout[1]), .b_valid(b_valid[1]),
        .busy(busy[1]));
    vmicro16_bram_dp #(.MEM_WIDTH(16), .MEM_DEPTH(16), .WRITE_MODE(2)) u2 (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[2]), .a_valid(a_valid[2]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout[2]), .b_valid(b_valid[2]),
        .busy(busy[2]));
    vmicro16_bram_dp #(.MEM_WIDTH(16), .MEM_DEPTH(12), .WRITE_MODE(0)) u3 (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout[3]), .a_valid(a_valid[3]),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout[3]), .b_valid(b_valid[3]),
        .busy(busy[3]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic en, input logic we, input logic [3:0] addr, input logic [15:0] din);
        a_en = en; a_we = we; a_addr = addr; a_din = din;
    endtask

    task automatic set_b(input logic en, input logic we, input logic [3:0] addr, input logic [15:0] din);
        b_en = en; b_we = we; b_addr = addr; b_din = din;
    endtask

    task automatic idle;
        set_a(1'b0, 1'b0, 4'd0, 16'h0);
        set_b(1'b0, 1'b0, 4'd0, 16'h0);
    endtask

    initial begin
        int n0;
        int n3;
        logic any_valid;
        logic [15:0] exp_cell;

        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_a_dout", a_dout[0], 16'h0000);
        chk("rst_b_dout", b_dout[0], 16'h0000);
        chk("rst_a_valid", 16'(a_valid[0]), 16'h0);
        chk("rst_b_valid", 16'(b_valid[0]), 16'h0);
        chk("rst_busy", 16'(busy[0]), 16'h1);
        chk("rst_busy_d12", 16'(busy[3]), 16'h1);

        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        // Preload a marker, then check the clear wipes it.
        set_a(1'b1, 1'b1, 4'd5, 16'hBEEF);
        tick();
        set_a(1'b1, 1'b0, 4'd5, 16'h0);
        tick();
        chk("preload_rd", a_dout[0], 16'hBEEF);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n0 = 0;
        n3 = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy[0]) n0++;
            if (busy[3]) n3++;
            tick();
        end
        chk("clr_len_d16", 16'(n0), 16'd16);
        chk("clr_len_d12", 16'(n3), 16'd12);
        set_a(1'b1, 1'b0, 4'd5, 16'h0);
        tick();
        chk("clr_rd5", a_dout[0], 16'h0000);
        chk("clr_rd5_valid", 16'(a_valid[0]), 16'h1);

        // A writes, B reads the same cell next cycle.
        set_a(1'b1, 1'b1, 4'd3, 16'h1234);
        tick();
        chk("wr3_a_valid", 16'(a_valid[0]), 16'h1);
        set_a(1'b0, 1'b0, 4'd0, 16'h0);
        set_b(1'b1, 1'b0, 4'd3, 16'h0);
        tick();
        chk("b_rd3", b_dout[0], 16'h1234);
        chk("b_rd3_valid", 16'(b_valid[0]), 16'h1);
        idle();
        tick();
        chk("idle_a_valid", 16'(a_valid[0]), 16'h0);
        chk("idle_b_valid", 16'(b_valid[0]), 16'h0);
        chk("idle_b_hold", b_dout[0], 16'h1234);

        // Read-during-write modes on port A.
        set_a(1'b1, 1'b1, 4'd7, 16'hAAAA);
        tick();
        set_a(1'b1, 1'b0, 4'd3, 16'h0);
        tick();
        chk("pre_nc_rd3", a_dout[2], 16'h1234);
        set_a(1'b1, 1'b1, 4'd7, 16'h5555);
        tick();
        chk("wm_write_first", a_dout[0], 16'h5555);
        chk("wm_read_first", a_dout[1], 16'hAAAA);
        chk("wm_no_change", a_dout[2], 16'h1234);
        chk("wm_nc_valid", 16'(a_valid[2]), 16'h1);

        // Cross-port collisions at address 2.
        set_a(1'b1, 1'b1, 4'd2, 16'h1111);
        set_b(1'b1, 1'b1, 4'd2, 16'h2222);
        tick();
        chk("coll_b_wf", b_dout[0], 16'h2222);
        chk("coll_a_rf", a_dout[1], 16'h0000);
        set_a(1'b1, 1'b0, 4'd2, 16'h0);
        set_b(1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        chk("coll_a_wins", a_dout[0], 16'h1111);
        chk("coll_a_wins_rf", a_dout[1], 16'h1111);
        set_a(1'b1, 1'b1, 4'd2, 16'h3333);
        set_b(1'b1, 1'b0, 4'd2, 16'h0);
        tick();
        chk("coll_b_old", b_dout[0], 16'h1111);
        set_a(1'b1, 1'b0, 4'd2, 16'h0);
        set_b(1'b0, 1'b0, 4'd0, 16'h0);
        tick();
        chk("coll_new", a_dout[0], 16'h3333);

        // Out-of-range on the 12-deep instance; in range on the 16-deep one.
        set_a(1'b1, 1'b1, 4'd13, 16'hFFFF);
        tick();
        set_a(1'b1, 1'b0, 4'd13, 16'h0);
        tick();
        chk("oor_rd", a_dout[3], 16'h0000);
        chk("oor_valid", 16'(a_valid[3]), 16'h1);
        chk("inr_rd13", a_dout[0], 16'hFFFF);
        for (int i = 0; i < 12; i++) begin
            set_a(1'b1, 1'b0, 4'(i), 16'h0);
            tick();
            case (i)
                2:       exp_cell = 16'h3333;
                3:       exp_cell = 16'h1234;
                7:       exp_cell = 16'h5555;
                default: exp_cell = 16'h0000;
            endcase
            chk($sformatf("oor_cell%0d", i), a_dout[3], exp_cell);
        end

        // Reset again part-way through a clear, with requests pushed while busy.
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n0 = 0;
        any_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy[0]) begin
                n0++;
                set_a(1'b1, 1'b1, 4'd9, 16'h9999);
                set_b(1'b1, 1'b0, 4'd3, 16'h0);
            end else begin
                idle();
            end
            tick();
            if (busy[0] || i == 0) any_valid = any_valid | a_valid[0] | b_valid[0];
        end
        chk("reclr_len", 16'(n0), 16'd16);
        chk("busy_no_valid", 16'(any_valid), 16'h0);
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b0, 4'(i), 16'h0);
            tick();
            chk($sformatf("reclr_cell%0d", i), a_dout[0], 16'h0000);
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
